// File: rtl/ex_stage_md_pkg.sv
// Shared constants for the execute stage: aluop encodings, multiply/divide FSM
// states and op selects, and the legacy enable constants.
package ex_pkg;

    localparam logic [7:0] EXE_NOP_OP  = 8'h00;
    localparam logic [7:0] EXE_ADD_OP  = 8'h01;
    localparam logic [7:0] EXE_SUB_OP  = 8'h02;
    localparam logic [7:0] EXE_AND_OP  = 8'h03;
    localparam logic [7:0] EXE_OR_OP   = 8'h04;
    localparam logic [7:0] EXE_XOR_OP  = 8'h05;
    localparam logic [7:0] EXE_SLT_OP  = 8'h06;
    localparam logic [7:0] EXE_LUI_OP  = 8'h07;
    localparam logic [7:0] EXE_JAL_OP  = 8'h08;
    localparam logic [7:0] EXE_BEQ_OP  = 8'h09;
    localparam logic [7:0] EXE_BNE_OP  = 8'h0A;
    localparam logic [7:0] EXE_LW_OP   = 8'h0B;
    localparam logic [7:0] EXE_SW_OP   = 8'h0C;
    localparam logic [7:0] EXE_MUL_OP  = 8'h0D;
    localparam logic [7:0] EXE_DIVU_OP = 8'h0E;
    localparam logic [7:0] EXE_REMU_OP = 8'h0F;

    // Multiply/divide FSM states, kept as plain constants for older tools.
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_BUSY = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    localparam logic [1:0] MD_MUL  = 2'd0;
    localparam logic [1:0] MD_DIVU = 2'd1;
    localparam logic [1:0] MD_REMU = 2'd2;

    localparam logic Branch       = 1'b1;
    localparam logic NotBranch    = 1'b0;
    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam int               ZERO_WORD_W = 32;
    localparam logic [ZERO_WORD_W-1:0] ZeroWord = '0;

endpackage

// File: rtl/ex_stage_md_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage. The master (decode side) drives
// the *_i fields; the slave (ex_stage_md) drives the *_o fields and md_state.
interface ex_stage_md_if #(
    parameter int WIDTH   = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 8
);
    // Handshake: while stall_req_o is 1 the master holds every *_i field
    // stable and EX/MEM loads a bubble; the stage is accepted when it is 0.
    logic               flush_i;
    logic [WIDTH-1:0]   pc_i;
    logic [ALUOP_W-1:0] aluop_i;
    logic [WIDTH-1:0]   reg1_i;
    logic [WIDTH-1:0]   reg2_i;
    logic [WIDTH-1:0]   imm_i;
    logic [REG_AW-1:0]  wd_i;
    logic               wreg_i;

    logic               stall_req_o;
    logic [REG_AW-1:0]  wd_o;
    logic               wreg_o;
    logic [WIDTH-1:0]   wdata_o;
    logic [ALUOP_W-1:0] aluop_o;
    logic               branch_flag_o;
    logic [WIDTH-1:0]   branch_target_address_o;
    logic [WIDTH-1:0]   mem_addr_o;
    logic               mem_ce_o;
    logic               mem_we_o;
    logic [WIDTH-1:0]   mem_data_o;
    logic [1:0]         md_state;

    modport master (
        output flush_i, pc_i, aluop_i, reg1_i, reg2_i, imm_i, wd_i, wreg_i,
        input  stall_req_o, wd_o, wreg_o, wdata_o, aluop_o, branch_flag_o,
               branch_target_address_o, mem_addr_o, mem_ce_o, mem_we_o,
               mem_data_o, md_state
    );

    modport slave (
        input  flush_i, pc_i, aluop_i, reg1_i, reg2_i, imm_i, wd_i, wreg_i,
        output stall_req_o, wd_o, wreg_o, wdata_o, aluop_o, branch_flag_o,
               branch_target_address_o, mem_addr_o, mem_ce_o, mem_we_o,
               mem_data_o, md_state
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative engine: unsigned shift-add multiply (low WIDTH bits) and restoring
// unsigned divide/remainder, one bit per cycle over WIDTH cycles.
module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       state
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    // acc: product or partial remainder; x: multiplier or dividend/quotient;
    // y: shifting multiplicand or fixed divisor.
    logic [WIDTH-1:0] acc_q, x_q, y_q, res_q;
    logic [WIDTH-1:0] acc_n, x_n, y_n, res_n;
    logic [WIDTH:0]   tmp, diff;
    logic             unused_diff_msb;

    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        acc_n = acc_q;
        x_n   = x_q;
        y_n   = y_q;
        tmp   = {acc_q, x_q[WIDTH-1]};
        diff  = tmp - {1'b0, y_q};
        if (op_q == MD_MUL) begin
            if (x_q[0]) acc_n = acc_q + y_q;
            x_n = x_q >> 1;
            y_n = y_q << 1;
        end else if (tmp >= {1'b0, y_q}) begin
            acc_n = diff[WIDTH-1:0];
            x_n   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = tmp[WIDTH-1:0];
            x_n   = {x_q[WIDTH-2:0], 1'b0};
        end
        res_n = (op_q == MD_DIVU) ? x_n : acc_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        cnt_q   <= CW'(WIDTH);
                        acc_q   <= '0;
                        x_q     <= (op == MD_MUL) ? b : a;
                        y_q     <= (op == MD_MUL) ? a : b;
                        state_q <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (flush) begin
                        state_q <= MD_IDLE;
                    end else begin
                        acc_q <= acc_n;
                        x_q   <= x_n;
                        y_q   <= y_n;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= MD_DONE;
                            res_q   <= res_n;
                        end
                    end
                end
                // DONE always returns to IDLE so the still-held op cannot restart.
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy   = (state_q == MD_BUSY);
    assign done   = (state_q == MD_DONE);
    assign result = res_q;
    assign state  = state_q;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: combinational ALU/branch/jump/load-store decode plus an optional
// iterative MUL/DIVU/REMU engine, built only when EX_MULDIV_EN is defined.
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 8
) (
    input logic          clk,
    input logic          rst,
    ex_stage_md_if.slave bus
);
    logic             md_req;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic             md_kill;

`ifdef EX_MULDIV_EN
    logic       is_md;
    logic [1:0] md_op;

    always_comb begin
        is_md = 1'b1;
        md_op = MD_MUL;
        case (bus.aluop_i)
            ALUOP_W'(EXE_MUL_OP):  md_op = MD_MUL;
            ALUOP_W'(EXE_DIVU_OP): md_op = MD_DIVU;
            ALUOP_W'(EXE_REMU_OP): md_op = MD_REMU;
            default:               is_md = 1'b0;
        endcase
    end

    // A new request is only possible in IDLE; the stall it raises is combinational.
    assign md_req = is_md & ~md_busy & ~md_done;

    ex_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_req),
        .op     (md_op),
        .a      (bus.reg1_i),
        .b      (bus.reg2_i),
        .flush  (bus.flush_i),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result),
        .state  (bus.md_state)
    );
`else
    logic unused_md_inputs;

    assign unused_md_inputs = clk ^ bus.flush_i;
    assign md_req       = 1'b0;
    assign md_busy      = 1'b0;
    assign md_done      = 1'b0;
    assign md_result    = '0;
    assign bus.md_state = MD_IDLE;
`endif

    assign md_kill = bus.flush_i & (md_busy | md_done);

    always_comb begin
        bus.stall_req_o             = 1'b0;
        bus.wd_o                    = '0;
        bus.wreg_o                  = WriteDisable;
        bus.wdata_o                 = '0;
        bus.aluop_o                 = bus.aluop_i;
        bus.branch_flag_o           = NotBranch;
        bus.branch_target_address_o = '0;
        bus.mem_addr_o              = '0;
        bus.mem_ce_o                = ChipDisable;
        bus.mem_we_o                = WriteDisable;
        bus.mem_data_o              = '0;
        if (rst || md_kill) begin
            bus.aluop_o = '0;
        end else begin
            bus.stall_req_o = md_busy | md_req;
            case (bus.aluop_i)
                ALUOP_W'(EXE_ADD_OP), ALUOP_W'(EXE_SUB_OP), ALUOP_W'(EXE_AND_OP),
                ALUOP_W'(EXE_OR_OP), ALUOP_W'(EXE_XOR_OP), ALUOP_W'(EXE_SLT_OP),
                ALUOP_W'(EXE_LUI_OP): begin
                    bus.wd_o   = bus.wd_i;
                    bus.wreg_o = bus.wreg_i;
                    case (bus.aluop_i)
                        ALUOP_W'(EXE_ADD_OP): bus.wdata_o = bus.reg1_i + bus.reg2_i;
                        ALUOP_W'(EXE_SUB_OP): bus.wdata_o = bus.reg1_i - bus.reg2_i;
                        ALUOP_W'(EXE_AND_OP): bus.wdata_o = bus.reg1_i & bus.reg2_i;
                        ALUOP_W'(EXE_OR_OP):  bus.wdata_o = bus.reg1_i | bus.reg2_i;
                        ALUOP_W'(EXE_XOR_OP): bus.wdata_o = bus.reg1_i ^ bus.reg2_i;
                        ALUOP_W'(EXE_SLT_OP):
                            bus.wdata_o = WIDTH'($signed(bus.reg1_i) < $signed(bus.reg2_i));
                        default:              bus.wdata_o = bus.imm_i;
                    endcase
                end
                ALUOP_W'(EXE_JAL_OP): begin
                    bus.wd_o                    = bus.wd_i;
                    bus.wreg_o                  = bus.wreg_i;
                    bus.wdata_o                 = bus.pc_i + WIDTH'(4);
                    bus.branch_flag_o           = Branch;
                    bus.branch_target_address_o = bus.pc_i + bus.imm_i;
                end
                ALUOP_W'(EXE_BEQ_OP), ALUOP_W'(EXE_BNE_OP): begin
                    if ((bus.reg1_i == bus.reg2_i) == (bus.aluop_i == ALUOP_W'(EXE_BEQ_OP))) begin
                        bus.branch_flag_o           = Branch;
                        bus.branch_target_address_o = bus.pc_i + bus.imm_i;
                    end
                end
                ALUOP_W'(EXE_LW_OP): begin
                    bus.wd_o       = bus.wd_i;
                    bus.wreg_o     = bus.wreg_i;
                    bus.mem_ce_o   = ChipEnable;
                    bus.mem_addr_o = bus.reg1_i + bus.imm_i;
                end
                ALUOP_W'(EXE_SW_OP): begin
                    bus.mem_ce_o   = ChipEnable;
                    bus.mem_we_o   = WriteEnable;
                    bus.mem_addr_o = bus.reg1_i + bus.imm_i;
                    bus.mem_data_o = bus.reg2_i;
                end
                ALUOP_W'(EXE_MUL_OP), ALUOP_W'(EXE_DIVU_OP), ALUOP_W'(EXE_REMU_OP): begin
                    if (md_done) begin
                        bus.wd_o    = bus.wd_i;
                        bus.wreg_o  = bus.wreg_i;
                        bus.wdata_o = md_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md; covers the multiply/divide engine when
// EX_MULDIV_EN is defined and its NOP behaviour otherwise.
module tb_ex_stage_md;
    import ex_pkg::*;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [WIDTH-1:0] exp_q[$];

    ex_stage_md_if #(.WIDTH(WIDTH), .REG_AW(5), .ALUOP_W(8)) bus ();

    ex_stage_md #(.WIDTH(WIDTH), .REG_AW(5), .ALUOP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] wd, input logic wreg);
        bus.aluop_i = op;
        bus.reg1_i  = r1;
        bus.reg2_i  = r2;
        bus.imm_i   = imm;
        bus.pc_i    = pc;
        bus.wd_i    = wd;
        bus.wreg_i  = wreg;
    endtask

`ifdef EX_MULDIV_EN
    task automatic run_md(input string tag, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] exp_v;
        tick();
        drive(op, a, b, 32'd0, 32'd0, 5'd5, 1'b1);
        #2;
        n = 0;
        while (bus.stall_req_o === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #3;
        end
        exp_v = exp_q.pop_front();
        check({tag, "_stall_cycles"}, n, WIDTH + 1);
        check({tag, "_state_done"}, 32'(bus.md_state), 32'(MD_DONE));
        check({tag, "_wdata"}, bus.wdata_o, exp_v);
        check({tag, "_wreg"}, 32'(bus.wreg_o), 32'd1);
        check({tag, "_wd"}, 32'(bus.wd_o), 32'd5);
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        bus.flush_i = 1'b0;
        drive(EXE_ADD_OP, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1);
        tick();
        tick();
        #2;
        check("rst_wdata", bus.wdata_o, 32'd0);
        check("rst_aluop", 32'(bus.aluop_o), 32'd0);
        check("rst_wreg", 32'(bus.wreg_o), 32'd0);
        check("rst_stall", 32'(bus.stall_req_o), 32'd0);
        check("rst_state", 32'(bus.md_state), 32'(MD_IDLE));

        tick();
        rst = 1'b0;
        #2;
        check("add_wdata", bus.wdata_o, 32'd12);
        check("add_wd", 32'(bus.wd_o), 32'd3);
        check("add_wreg", 32'(bus.wreg_o), 32'd1);
        check("add_stall", 32'(bus.stall_req_o), 32'd0);
        check("add_aluop", 32'(bus.aluop_o), 32'(EXE_ADD_OP));

        tick();
        bus.flush_i = 1'b1;
        #2;
        check("flush_idle_add", bus.wdata_o, 32'd12);
        bus.flush_i = 1'b0;

        tick();
        drive(EXE_SUB_OP, 32'd5, 32'd7, 32'd0, 32'd0, 5'd4, 1'b1);
        #2;
        check("sub_wrap", bus.wdata_o, 32'hFFFF_FFFE);

        tick();
        drive(EXE_SLT_OP, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd4, 1'b1);
        #2;
        check("slt_neg_lt_pos", bus.wdata_o, 32'd1);
        drive(EXE_SLT_OP, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd4, 1'b1);
        #2;
        check("slt_pos_lt_neg", bus.wdata_o, 32'd0);

        drive(EXE_XOR_OP, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'd0, 5'd4, 1'b1);
        #2;
        check("xor", bus.wdata_o, 32'h0000_FF00);

        drive(EXE_LUI_OP, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd4, 1'b1);
        #2;
        check("lui", bus.wdata_o, 32'h1234_5000);

        tick();
        drive(EXE_JAL_OP, 32'd0, 32'd0, 32'h40, 32'h200, 5'd1, 1'b1);
        #2;
        check("jal_link", bus.wdata_o, 32'h204);
        check("jal_flag", 32'(bus.branch_flag_o), 32'd1);
        check("jal_target", bus.branch_target_address_o, 32'h240);

        drive(EXE_BEQ_OP, 32'd9, 32'd9, 32'h20, 32'h100, 5'd2, 1'b1);
        #2;
        check("beq_flag", 32'(bus.branch_flag_o), 32'd1);
        check("beq_target", bus.branch_target_address_o, 32'h120);
        check("beq_wreg", 32'(bus.wreg_o), 32'd0);
        drive(EXE_BNE_OP, 32'd9, 32'd9, 32'h20, 32'h100, 5'd2, 1'b1);
        #2;
        check("bne_flag", 32'(bus.branch_flag_o), 32'd0);

        tick();
        drive(EXE_LW_OP, 32'h1000, 32'd0, 32'd8, 32'd0, 5'd6, 1'b1);
        #2;
        check("lw_addr", bus.mem_addr_o, 32'h1008);
        check("lw_ce_we", {30'd0, bus.mem_ce_o, bus.mem_we_o}, 32'd2);
        check("lw_wreg", 32'(bus.wreg_o), 32'd1);

        drive(EXE_SW_OP, 32'h1000, 32'hAB, 32'hFFFF_FFFC, 32'd0, 5'd6, 1'b1);
        #2;
        check("sw_addr", bus.mem_addr_o, 32'hFFC);
        check("sw_ce_we", {30'd0, bus.mem_ce_o, bus.mem_we_o}, 32'd3);
        check("sw_data", bus.mem_data_o, 32'hAB);
        check("sw_wreg", 32'(bus.wreg_o), 32'd0);

`ifdef EX_MULDIV_EN
        exp_q.push_back(32'd42);
        run_md("mul_7x6", EXE_MUL_OP, 32'd7, 32'd6);
        tick();
        drive(EXE_NOP_OP, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #2;
        check("mul_after_idle", 32'(bus.md_state), 32'(MD_IDLE));
        check("mul_after_stall", 32'(bus.stall_req_o), 32'd0);

        exp_q.push_back(32'd14);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'd5);
        run_md("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7);
        run_md("remu_100_7", EXE_REMU_OP, 32'd100, 32'd7);
        run_md("divu_5_0", EXE_DIVU_OP, 32'd5, 32'd0);
        run_md("remu_5_0", EXE_REMU_OP, 32'd5, 32'd0);

        for (int k = 0; k < 2; k++) begin
            tick();
            drive(EXE_MUL_OP, 32'd7, 32'd6, 32'd0, 32'd0, 5'd5, 1'b1);
            repeat (10) tick();
            #2;
            check(k == 0 ? "flush_pre_state" : "rst_pre_state", 32'(bus.md_state), 32'(MD_BUSY));
            if (k == 0) bus.flush_i = 1'b1;
            else        rst = 1'b1;
            #1;
            check(k == 0 ? "flush_stall" : "rstmid_stall", 32'(bus.stall_req_o), 32'd0);
            check(k == 0 ? "flush_wreg" : "rstmid_wreg", 32'(bus.wreg_o), 32'd0);
            check(k == 0 ? "flush_wdata" : "rstmid_wdata", bus.wdata_o, 32'd0);
            tick();
            bus.flush_i = 1'b0;
            rst = 1'b0;
            drive(EXE_NOP_OP, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
            #2;
            check(k == 0 ? "flush_next_stall" : "rstmid_next_stall", 32'(bus.stall_req_o), 32'd0);
            check(k == 0 ? "flush_next_state" : "rstmid_next_state", 32'(bus.md_state), 32'(MD_IDLE));
        end
`else
        tick();
        drive(EXE_MUL_OP, 32'd7, 32'd6, 32'd0, 32'd0, 5'd5, 1'b1);
        #2;
        check("mul_off_stall", 32'(bus.stall_req_o), 32'd0);
        check("mul_off_wreg", 32'(bus.wreg_o), 32'd0);
        check("mul_off_wdata", bus.wdata_o, 32'd0);
        check("mul_off_aluop", 32'(bus.aluop_o), 32'(EXE_MUL_OP));
        tick();
        drive(EXE_DIVU_OP, 32'd100, 32'd7, 32'd0, 32'd0, 5'd5, 1'b1);
        #2;
        check("divu_off_stall", 32'(bus.stall_req_o), 32'd0);
        check("divu_off_wdata", bus.wdata_o, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised successor execute stage for the in-order pipeline, between ID/EX and EX/MEM registers. Executes single-cycle ALU, branch, jump and load/store-address ops combinationally as before, and adds an iterative multiply/divide engine that holds the pipeline via a stall request. Results, branch redirect and memory request go to EX/MEM and the PC unit.

## Interface
- WIDTH, 32, datapath and register width
- REG_AW, 5, register address width
- ALUOP_W, 8, aluop field width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  kill in-flight multi-cycle op
- pc_i  in  WIDTH  PC of current instruction
- aluop_i  in  ALUOP_W  decoded operation
- reg1_i, reg2_i, imm_i  in  WIDTH  operands, sign-extended immediate
- wd_i  in  REG_AW  destination register
- wreg_i  in  1  write-back request
- stall_req_o  out  1  hold IF/ID/EX; EX/MEM takes a bubble
- wd_o  out  REG_AW; wreg_o  out  1; wdata_o  out  WIDTH  write-back
- aluop_o  out  ALUOP_W  pass-through to MEM
- branch_flag_o  out  1; branch_target_address_o  out  WIDTH
- mem_addr_o  out  WIDTH; mem_ce_o, mem_we_o  out  1; mem_data_o  out  WIDTH

## Operation
- Defaults every cycle: all outputs zero. aluop_o = aluop_i, except 0 (NOP) in rst.
- ADD/SUB/AND/OR/XOR: result of reg1_i op reg2_i, modulo 2^WIDTH. SLT: signed, result 1/0. LUI: imm_i. wd_o/wreg_o from wd_i/wreg_i.
- JAL: wdata_o = pc_i+4, branch_flag_o=1, target = pc_i+imm_i.
- BEQ/BNE: no write-back. On condition true, branch_flag_o=1, target = pc_i+imm_i.
- LW: mem_ce_o=1, mem_we_o=0, mem_addr_o = reg1_i+imm_i, write-back fields passed through. SW: mem_ce_o=1, mem_we_o=1, same address, mem_data_o = reg2_i, no write-back.
- MUL (low WIDTH bits, unsigned shift-add), DIVU, REMU (restoring, unsigned): multi-cycle through the FSM.
  - IDLE: MD op present → latch operands, load counter with WIDTH, stall_req_o=1, go BUSY.
  - BUSY: one iteration per cycle; stall_req_o=1. Counter hits 0 → go DONE.
  - DONE: stall_req_o=0. wdata_o = result register. wd_o/wreg_o from the held inputs. Go IDLE unconditionally, so the held op does not restart.
- Divide by zero: quotient all-ones, remainder = dividend. No trap.
- flush_i in BUSY or DONE → IDLE next edge; outputs already zero that cycle, stall_req_o=0. flush_i in IDLE has no effect.
- rst high: FSM IDLE, counter and result zero, all outputs zero. This includes reset mid-BUSY.

## Timing
- Single-cycle ops: outputs are combinational from inputs, zero latency, no stall.
- MD op arriving at cycle 0 behaves as follows:
  - stall_req_o is high in cycles 0..WIDTH (WIDTH+1 cycles).
  - The result is valid with stall_req_o low in cycle WIDTH+1.
  - EX/MEM captures the result at the end of cycle WIDTH+1.
- Upstream keeps all *_i stable while stall_req_o=1. Back-to-back MD ops: the second begins in IDLE on the cycle after DONE.
- stall_req_o depends combinationally on aluop_i in IDLE (request in cycle 0); registered state otherwise.

## Configuration
- EX_MULDIV_EN defined: MUL/DIVU/REMU executed as above.
- EX_MULDIV_EN undefined: FSM and engine are not built, and stall_req_o is tied 0. The three ops behave as NOP: wreg_o=0, wdata_o=0.

## Structure
- Package ex_pkg holds:
  - aluop encodings (EXE_*_OP)
  - FSM state enum (IDLE/BUSY/DONE)
  - Branch/Chip/Write enable constants
  - ZeroWord width helper
- Sub-module ex_muldiv_iter (WIDTH param) contains:
  - the FSM, counter and shift registers
  - start/op/a/b/flush inputs
  - busy/done/result outputs
- The top level holds the combinational decode and the output mux.

## Test plan
- ADD 5+7, wd_i=3, wreg_i=1 → wdata_o=12, wd_o=3, wreg_o=1, stall_req_o=0 same cycle.
- BEQ reg1=reg2=9, pc=0x100, imm=0x20 → branch_flag_o=1, target=0x120, wreg_o=0. BNE with same operands → branch_flag_o=0.
- SW reg1=0x1000, imm=-4, reg2=0xAB → mem_addr_o=0xFFC, mem_we_o=1, mem_ce_o=1, mem_data_o=0xAB.
- MUL 7*6 (WIDTH=32) → stall_req_o high 33 cycles, then 1 cycle wdata_o=42, wreg_o=1. Next cycle FSM IDLE.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5.
- MUL started, flush_i at BUSY cycle 10 → stall_req_o=0 next cycle, no write-back. Repeat the scenario with rst instead of flush_i: same response.
